// File: rtl/afe_spi_arbiter.sv
// Round-robin arbiter that shares one write-only SPI shifter between two requesters
// and serialises each accepted word onto the addressed AFE's SCLK/SDI/LE lines.
//
// state    | meaning
// IDLE     | waiting for a request; grants and pulses done of the previous owner
// SHIFT_LO | SCLK low, SDI presents the current bit, CLK_DIV cycles
// SHIFT_HI | SCLK high, SDI held, CLK_DIV cycles; bit counter advances at the end
// LATCH    | LE high for LE_CYCLES after the last bit
// GAP      | all lines low for GAP_CYCLES before returning to IDLE
module afe_spi_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 8,
    parameter int LE_CYCLES  = 4,
    parameter int GAP_CYCLES = 4
) (
    input  logic                  sysClk,
    input  logic                  sysRst_n,
    input  logic                  req0_valid,
    input  logic                  req0_sel,
    input  logic [DATA_WIDTH-1:0] req0_data,
    output logic                  req0_ready,
    output logic                  req0_done,
    input  logic                  req1_valid,
    input  logic                  req1_sel,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  req1_done,
    output logic                  busy,
    output logic [1:0]            AFE_SPI_CLK,
    output logic [1:0]            AFE_SPI_SDI,
    output logic [1:0]            AFE_SPI_LE
);

    localparam int HP_W     = $clog2(CLK_DIV + 1);
    localparam int BIT_W    = $clog2(DATA_WIDTH + 1);
    localparam int WAIT_MAX = (LE_CYCLES > GAP_CYCLES) ? LE_CYCLES : GAP_CYCLES;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

    localparam logic [HP_W-1:0]   HP_LOAD  = HP_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0]  BIT_LOAD = BIT_W'(DATA_WIDTH - 1);
    localparam logic [WAIT_W-1:0] LE_LOAD  = WAIT_W'(LE_CYCLES - 1);
    localparam logic [WAIT_W-1:0] GAP_LOAD = WAIT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        GAP
    } state_t;

    state_t                state;
    logic [HP_W-1:0]       hp_cnt;
    logic [BIT_W-1:0]      bit_cnt;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  sel_q;
    logic                  owner_q;
    logic                  last_grant;
    logic                  run_q;
    logic                  clk_q;
    logic                  le_q;
    logic [1:0]            done_q;

    logic                  grant;
    logic                  accept;
    logic                  g_sel;
    logic [DATA_WIDTH-1:0] g_data;
    logic                  sdi_bit;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) grant = ~last_grant;
        else                          grant = req1_valid;
    end

    // run_q keeps ready low while reset is asserted and for the first cycle after it
    assign accept     = run_q && (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = accept && !grant;
    assign req1_ready = accept && grant;
    assign busy       = accept || (state != IDLE);
    assign g_sel      = grant ? req1_sel : req0_sel;
    assign g_data     = grant ? req1_data : req0_data;

    always_ff @(posedge sysClk or negedge sysRst_n) begin
        if (!sysRst_n) begin
            state      <= IDLE;
            hp_cnt     <= '0;
            bit_cnt    <= '0;
            wait_cnt   <= '0;
            shreg      <= '0;
            sel_q      <= 1'b0;
            owner_q    <= 1'b0;
            last_grant <= 1'b1;
            run_q      <= 1'b0;
            clk_q      <= 1'b0;
            le_q       <= 1'b0;
            done_q     <= 2'b00;
        end else begin
            run_q  <= 1'b1;
            done_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner_q    <= grant;
                        last_grant <= grant;
                        sel_q      <= g_sel;
                        shreg      <= g_data;
                        bit_cnt    <= BIT_LOAD;
                        hp_cnt     <= HP_LOAD;
                        clk_q      <= 1'b0;
                        le_q       <= 1'b0;
                        state      <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (hp_cnt == '0) begin
                        hp_cnt <= HP_LOAD;
                        clk_q  <= 1'b1;
                        state  <= SHIFT_HI;
                    end else begin
                        hp_cnt <= hp_cnt - 1'b1;
                    end
                end
                SHIFT_HI: begin
                    if (hp_cnt == '0) begin
                        clk_q  <= 1'b0;
                        hp_cnt <= HP_LOAD;
                        if (bit_cnt == '0) begin
                            le_q     <= 1'b1;
                            wait_cnt <= LE_LOAD;
                            state    <= LATCH;
                        end else begin
                            bit_cnt <= bit_cnt - 1'b1;
                            shreg   <= {shreg[DATA_WIDTH-2:0], 1'b0};
                            state   <= SHIFT_LO;
                        end
                    end else begin
                        hp_cnt <= hp_cnt - 1'b1;
                    end
                end
                LATCH: begin
                    if (wait_cnt == '0) begin
                        le_q     <= 1'b0;
                        wait_cnt <= GAP_LOAD;
                        state    <= GAP;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                GAP: begin
                    if (wait_cnt == '0) begin
                        done_q[owner_q] <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sdi_bit     = ((state == SHIFT_LO) || (state == SHIFT_HI)) && shreg[DATA_WIDTH-1];
    assign AFE_SPI_CLK = sel_q ? {clk_q, 1'b0}   : {1'b0, clk_q};
    assign AFE_SPI_SDI = sel_q ? {sdi_bit, 1'b0} : {1'b0, sdi_bit};
    assign AFE_SPI_LE  = sel_q ? {le_q, 1'b0}    : {1'b0, le_q};
    assign req0_done   = done_q[0];
    assign req1_done   = done_q[1];

endmodule

// File: tb/tb_afe_spi_arbiter.sv
// Directed bench for afe_spi_arbiter: single-write vector table, then contention,
// queued request, mid-shift reset and a narrow-parameter instance.
module tb_afe_spi_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       r0v = 1'b0, r0s = 1'b0, r1v = 1'b0, r1s = 1'b0;
    logic [7:0] r0d = '0, r1d = '0;
    logic       r0rdy, r0done, r1rdy, r1done, busy;
    logic [1:0] sclk, sdi, le;

    logic        pv = 1'b0, ps = 1'b0, p1v = 1'b0, p1s = 1'b0;
    logic [23:0] pd = '0, p1d = '0;
    logic        prdy, pdone, p1rdy, p1done, pbusy;
    logic [1:0]  psclk, psdi, ple;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    afe_spi_arbiter dut (
        .sysClk(clk), .sysRst_n(rst_n),
        .req0_valid(r0v), .req0_sel(r0s), .req0_data(r0d), .req0_ready(r0rdy), .req0_done(r0done),
        .req1_valid(r1v), .req1_sel(r1s), .req1_data(r1d), .req1_ready(r1rdy), .req1_done(r1done),
        .busy(busy), .AFE_SPI_CLK(sclk), .AFE_SPI_SDI(sdi), .AFE_SPI_LE(le)
    );

    afe_spi_arbiter #(.DATA_WIDTH(24), .CLK_DIV(1), .LE_CYCLES(1), .GAP_CYCLES(1)) dut_p (
        .sysClk(clk), .sysRst_n(rst_n),
        .req0_valid(pv), .req0_sel(ps), .req0_data(pd), .req0_ready(prdy), .req0_done(pdone),
        .req1_valid(p1v), .req1_sel(p1s), .req1_data(p1d), .req1_ready(p1rdy), .req1_done(p1done),
        .busy(pbusy), .AFE_SPI_CLK(psclk), .AFE_SPI_SDI(psdi), .AFE_SPI_LE(ple)
    );

    typedef struct {
        int         port;
        logic       sel;
        logic [7:0] data;
        int         exp_done;
        int         exp_le_f;
        int         exp_le_l;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        r0v = 1'b0; r1v = 1'b0; pv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    // present a request just after an edge; leaves time at the cycle-0 sample point
    task automatic start(input int port, input logic sel, input logic [7:0] d);
        @(posedge clk); #1;
        if (port == 0) begin r0v = 1'b1; r0s = sel; r0d = d; end
        else           begin r1v = 1'b1; r1s = sel; r1d = d; end
        #1;
    endtask

    // follows a transaction from cycle 1 until its done; returns at the done-cycle sample point
    task automatic watch(input int port, input logic sel, input int q_at,
                         output int done_c, output logic [7:0] bits, output int nb,
                         output int le_f, output int le_l, output int stray,
                         output int busy_bad, output int early);
        logic prev;
        logic mine, other_rdy;
        done_c = -1; bits = '0; nb = 0; le_f = -1; le_l = -1;
        stray = 0; busy_bad = 0; early = 0; prev = 1'b0;
        for (int c = 1; c <= 200 && done_c < 0; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                if (port == 0) r0v = 1'b0; else r1v = 1'b0;
            end
            if (c == q_at) begin r1v = 1'b1; r1s = 1'b1; r1d = 8'h3C; #1; end
            if (sclk[sel] && !prev) begin bits = {bits[6:0], sdi[sel]}; nb++; end
            prev = sclk[sel];
            if (le[sel]) begin
                if (le_f < 0) le_f = c;
                le_l = c;
            end
            if (sclk[!sel] || sdi[!sel] || le[!sel]) stray++;
            if (port == 0 ? r1done : r0done) stray++;
            mine      = (port == 0) ? r0done : r1done;
            other_rdy = (port == 0) ? r1rdy : r0rdy;
            if (!mine && other_rdy) early++;
            if (mine) done_c = c;
            if (busy != ((done_c < 0) || r0rdy || r1rdy)) busy_bad++;
        end
    endtask

    task automatic check_txn(input string tag, input logic [7:0] exp_bits, input int done_c,
                             input logic [7:0] bits, input int nb, input int le_f, input int le_l,
                             input int stray, input int busy_bad);
        chk({tag, "_bits"}, bits, exp_bits);
        chk({tag, "_nbits"}, nb, 8);
        chk({tag, "_le_first"}, le_f, 129);
        chk({tag, "_le_last"}, le_l, 132);
        chk({tag, "_done_cycle"}, done_c, 137);
        chk({tag, "_quiet_other"}, stray, 0);
        chk({tag, "_busy"}, busy_bad, 0);
    endtask

    vec_t       vecs[5];
    int         done_c, nb, le_f, le_l, stray, busy_bad, early;
    logic [7:0] bits;

    initial begin
        vecs[0] = '{0, 1'b0, 8'hA5, 137, 129, 132};
        vecs[1] = '{1, 1'b1, 8'h3C, 137, 129, 132};
        vecs[2] = '{0, 1'b1, 8'hFF, 137, 129, 132};
        vecs[3] = '{1, 1'b0, 8'h01, 137, 129, 132};
        vecs[4] = '{0, 1'b0, 8'h80, 137, 129, 132};

        @(posedge clk); #1;
        chk("reset_outputs", {sclk, sdi, le, busy, r0rdy, r1rdy, r0done, r1done}, 0);
        do_reset();

        for (int i = 0; i < 5; i++) begin
            start(vecs[i].port, vecs[i].sel, vecs[i].data);
            chk($sformatf("v%0d_ready", i), (vecs[i].port == 0) ? r0rdy : r1rdy, 1);
            chk($sformatf("v%0d_ready_other", i), (vecs[i].port == 0) ? r1rdy : r0rdy, 0);
            chk($sformatf("v%0d_busy0", i), busy, 1);
            watch(vecs[i].port, vecs[i].sel, -1, done_c, bits, nb, le_f, le_l, stray, busy_bad, early);
            chk($sformatf("v%0d_bits", i), bits, vecs[i].data);
            chk($sformatf("v%0d_nbits", i), nb, 8);
            chk($sformatf("v%0d_le_first", i), le_f, vecs[i].exp_le_f);
            chk($sformatf("v%0d_le_last", i), le_l, vecs[i].exp_le_l);
            chk($sformatf("v%0d_done_cycle", i), done_c, vecs[i].exp_done);
            chk($sformatf("v%0d_quiet_other", i), stray, 0);
            chk($sformatf("v%0d_busy", i), busy_bad, 0);
        end

        // contention straight after reset: requester 0 first, requester 1 on its done cycle
        do_reset();
        @(posedge clk); #1;
        r0v = 1'b1; r0s = 1'b0; r0d = 8'h11;
        r1v = 1'b1; r1s = 1'b1; r1d = 8'h22;
        #1;
        chk("cont_first_r0", r0rdy, 1);
        chk("cont_first_r1", r1rdy, 0);
        watch(0, 1'b0, -1, done_c, bits, nb, le_f, le_l, stray, busy_bad, early);
        check_txn("cont_a", 8'h11, done_c, bits, nb, le_f, le_l, stray, busy_bad);
        chk("cont_r1_waits", early, 0);
        chk("cont_r1_ready_at_done", r1rdy, 1);
        watch(1, 1'b1, -1, done_c, bits, nb, le_f, le_l, stray, busy_bad, early);
        check_txn("cont_b", 8'h22, done_c, bits, nb, le_f, le_l, stray, busy_bad);
        r0v = 1'b1; r0d = 8'h33; r1v = 1'b1; r1d = 8'h44;
        #1;
        chk("cont2_r0_after_r1", r0rdy, 1);
        chk("cont2_r1_held", r1rdy, 0);
        watch(0, 1'b0, -1, done_c, bits, nb, le_f, le_l, stray, busy_bad, early);
        chk("cont2_done_cycle", done_c, 137);
        chk("cont3_r1_after_r0", r1rdy, 1);
        watch(1, 1'b1, -1, done_c, bits, nb, le_f, le_l, stray, busy_bad, early);
        chk("cont3_bits", bits, 8'h44);

        // requester 1 arrives at cycle 50 of a requester 0 transfer
        start(0, 1'b0, 8'hC3);
        chk("queue_r0_ready", r0rdy, 1);
        watch(0, 1'b0, 50, done_c, bits, nb, le_f, le_l, stray, busy_bad, early);
        check_txn("queue_a", 8'hC3, done_c, bits, nb, le_f, le_l, stray, busy_bad);
        chk("queue_r1_no_early_ready", early, 0);
        chk("queue_r1_ready_with_done", r1rdy, 1);
        watch(1, 1'b1, -1, done_c, bits, nb, le_f, le_l, stray, busy_bad, early);
        check_txn("queue_b", 8'h3C, done_c, bits, nb, le_f, le_l, stray, busy_bad);

        // reset at cycle 60 of a requester 0 transfer
        start(0, 1'b0, 8'h5A);
        chk("rst_r0_ready", r0rdy, 1);
        for (int c = 1; c < 60; c++) begin
            @(posedge clk); #1;
            if (c == 1) r0v = 1'b0;
        end
        @(posedge clk); #1;
        chk("rst_shifting_before", busy, 1);
        r0v = 1'b1; r0s = 1'b0; r0d = 8'h96;
        r1v = 1'b1; r1s = 1'b1; r1d = 8'h69;
        rst_n = 1'b0;
        #1;
        chk("rst_outputs_zero", {sclk, sdi, le, busy, r0rdy, r1rdy, r0done, r1done}, 0);
        begin
            int dn = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (r0done || r1done || busy || r0rdy || r1rdy) dn++;
            end
            rst_n = 1'b1;
            @(posedge clk); #1;
            if (r0done || r1done) dn++;
            chk("rst_no_done", dn, 0);
        end
        chk("rst_r0_first", r0rdy, 1);
        chk("rst_r1_waits", r1rdy, 0);
        watch(0, 1'b0, -1, done_c, bits, nb, le_f, le_l, stray, busy_bad, early);
        check_txn("rst_after", 8'h96, done_c, bits, nb, le_f, le_l, stray, busy_bad);
        chk("rst_r1_next", r1rdy, 1);
        watch(1, 1'b1, -1, done_c, bits, nb, le_f, le_l, stray, busy_bad, early);
        chk("rst_r1_bits", bits, 8'h69);

        // narrow-parameter instance: 24-bit word, SCLK toggling every cycle
        begin
            logic [23:0] pbits = '0;
            int pn = 0, pdone_c = -1, tog_bad = 0, pstray = 0, ple_f = -1;
            logic pprev = 1'b0;
            @(posedge clk); #1;
            pv = 1'b1; ps = 1'b0; pd = 24'h800001;
            #1;
            chk("sweep_ready", prdy, 1);
            for (int c = 1; c <= 100 && pdone_c < 0; c++) begin
                @(posedge clk); #1;
                if (c == 1) pv = 1'b0;
                if (c <= 48 && psclk[0] != (c % 2 == 0)) tog_bad++;
                if (psclk[0] && !pprev) begin pbits = {pbits[22:0], psdi[0]}; pn++; end
                pprev = psclk[0];
                if (ple[0] && ple_f < 0) ple_f = c;
                if (psclk[1] || psdi[1] || ple[1] || p1rdy || p1done) pstray++;
                if (pdone) pdone_c = c;
            end
            chk("sweep_toggle", tog_bad, 0);
            chk("sweep_nbits", pn, 24);
            chk("sweep_msb", pbits[23], 1);
            chk("sweep_lsb", pbits[0], 1);
            chk("sweep_word", pbits, 24'h800001);
            chk("sweep_le_cycle", ple_f, 49);
            chk("sweep_done_cycle", pdone_c, 51);
            chk("sweep_busy_at_done", pbusy, 0);
            chk("sweep_quiet_other", pstray, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
